pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/exception-request sequencer for the five-stage pipeline.
- Produces the enable/flush/Req controls consumed by the PC register and by the F/D, D/E, E/M and M/W pipeline registers.
- Owns the multi-cycle multiply/divide busy counter, the data-hazard stall decision, the eret/EPC stall and delay-slot cancel, and a stall performance counter.
- Sits beside the datapath and is driven by decoded Tuse/Tnew info and the CP0 exception request.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu after the start cycle.
- DIV_CYCLES, 10, busy cycles for div/divu after the start cycle.
- CNT_W, 4, busy counter width; must satisfy DIV_CYCLES < 2**CNT_W and MULT_CYCLES < 2**CNT_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- Req  in  1  CP0 exception/interrupt request (M stage); forwarded as-is to all pipeline registers.
- D_rs  in  5  rs address of the D-stage instruction.
- D_rt  in  5  rt address of the D-stage instruction.
- D_Tuse_rs  in  2  cycles until D needs rs; 3 = not used.
- D_Tuse_rt  in  2  same, for rt.
- E_wa  in  5  E-stage destination register; 0 = none.
- E_Tnew  in  2  cycles until the E result is available.
- M_wa  in  5  M-stage destination register.
- M_Tnew  in  2  cycles until the M result is available.
- D_is_md  in  1  D instruction uses the MDU (mult/div/mfhi/mflo/mthi/mtlo).
- E_md_op  in  2  0 none, 1 mult/multu, 2 div/divu, 3 reserved (treated as none).
- D_eret  in  1  eret in D.
- E_mtc0_epc  in  1  mtc0 to CP0 reg 14 in E.
- M_mtc0_epc  in  1  mtc0 to CP0 reg 14 in M.
- pc_en  out  1  PC register enable.
- fd_en  out  1  F/D register enable.
- fd_flush  out  1  F/D register flush.
- de_flush  out  1  D/E register flush (bubble insert).
- md_start  out  1  qualified MDU start strobe.
- md_busy  out  1  MDU busy, including the start cycle.
- stall  out  1  pipeline stall.
- stall_cnt  out  32  total number of stalled cycles.

Behaviour:
- Reset values while reset=1: busy count=0, stall_cnt=0, pc_en=1, fd_en=1, fd_flush=0, de_flush=0, md_start=0, md_busy=0, stall=0. Reset overrides every other input.
- md_start = (E_md_op==1 || E_md_op==2) && !Req && !reset. An exception in M suppresses the start of the younger E instruction.
- Busy counter, on the clock edge:
  - if md_start: load MULT_CYCLES or DIV_CYCLES.
  - else if count != 0: decrement.
  - Req does not clear an operation that is already running; it finishes.
- md_busy = md_start || (count != 0). Combinational; high in the start cycle.
- Data-hazard stall on rs: D_rs != 0 && ((E_wa==D_rs && E_Tnew > D_Tuse_rs) || (M_wa==D_rs && M_Tnew > D_Tuse_rs)). The rt term is identical with rt signals.
- MDU stall: D_is_md && md_busy.
- EPC stall: D_eret && (E_mtc0_epc || M_mtc0_epc).
- stall = OR of the data-hazard, MDU and EPC terms, gated low when Req=1 (Req has priority).
- When stall=1: pc_en=0, fd_en=0, de_flush=1, fd_flush=0.
- When stall=0: pc_en=1, fd_en=1, de_flush=0.
- fd_flush = D_eret && !stall && !Req. This cancels the instruction fetched behind eret.
- When Req=1: stall=0, fd_flush=0, de_flush=0, pc_en=1, fd_en=1. The registers take their own Req path (load handler PC 0x4180, zero instr).
- stall_cnt increments by 1 on every clock edge where stall=1 and reset=0. It wraps from 0xFFFFFFFF to 0.
- All outputs except the counters are combinational from the inputs and the current count. There is no added latency.

Decomposition:
- Shared package (cpu_defs):
  - MD_NONE/MD_MULT/MD_DIV encodings.
  - TUSE_NONE=3.
  - CP0 reg index EPC=14.
  - Handler PC 32'h0000_4180.
- One natural sub-module: md_busy_cnt, holding the counter, load/decrement logic and md_busy.
- The hazard comparators stay inline.

Test Plan:
- lw in E (E_wa=8, E_Tnew=2) with add in D (D_rs=8, D_Tuse_rs=1) -> stall=1, pc_en=0, fd_en=0, de_flush=1 that cycle; stall_cnt +1. With D_rs=0 and the same E state -> stall=0.
- E_md_op=2 for one cycle, then D_is_md=1 held -> md_busy=1 for 11 consecutive cycles (start cycle plus 10), stall for the same 11, then stall=0. Repeat with E_md_op=1 -> 6 cycles.
- E_md_op=1 and Req=1 in the same cycle -> md_start=0, count stays 0, md_busy=0, stall=0. Req while count=7 -> counter continues 6,5,… to 0.
- D_eret=1 with M_mtc0_epc=1 -> stall=1, fd_flush=0. Next cycle with no mtc0 in E/M -> stall=0, fd_flush=1.
- Data hazard present and Req=1 together -> stall=0, de_flush=0, pc_en=1; stall_cnt unchanged.
- Assert reset mid-divide (count=4, stall_cnt=9) -> next cycle count=0, md_busy=0, stall_cnt=0, all outputs at reset values.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared encodings and constants for the hazard sequencer
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        MD_NONE = 2'd0,
        MD_MULT = 2'd1,
        MD_DIV  = 2'd2,
        MD_RSVD = 2'd3
    } md_op_e;

    localparam logic [1:0]  TUSE_NONE  = 2'd3;
    localparam logic [4:0]  CP0_EPC    = 5'd14;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - decode/CP0 inputs and pipeline-register controls of the hazard sequencer
interface pipe_hazard_ctrl_if;

    logic        Req;
    logic [4:0]  D_rs;
    logic [4:0]  D_rt;
    logic [1:0]  D_Tuse_rs;
    logic [1:0]  D_Tuse_rt;
    logic [4:0]  E_wa;
    logic [1:0]  E_Tnew;
    logic [4:0]  M_wa;
    logic [1:0]  M_Tnew;
    logic        D_is_md;
    logic [1:0]  E_md_op;
    logic        D_eret;
    logic        E_mtc0_epc;
    logic        M_mtc0_epc;

    logic        pc_en;
    logic        fd_en;
    logic        fd_flush;
    logic        de_flush;
    logic        md_start;
    logic        md_busy;
    logic        stall;
    logic [31:0] stall_cnt;

    modport master (
        output Req, D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, E_wa, E_Tnew, M_wa, M_Tnew,
               D_is_md, E_md_op, D_eret, E_mtc0_epc, M_mtc0_epc,
        input  pc_en, fd_en, fd_flush, de_flush, md_start, md_busy, stall, stall_cnt
    );

    modport slave (
        input  Req, D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, E_wa, E_Tnew, M_wa, M_Tnew,
               D_is_md, E_md_op, D_eret, E_mtc0_epc, M_mtc0_epc,
        output pc_en, fd_en, fd_flush, de_flush, md_start, md_busy, stall, stall_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_cnt.sv
// rtl/pipe_hazard_ctrl_md_busy_cnt.sv - multiply/divide busy counter
module pipe_hazard_ctrl_md_busy_cnt #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_div,
    output logic md_busy
);

    logic [CNT_W-1:0] count;

    // A running operation is never cancelled by an exception; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (md_start) begin
            count <= md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign md_busy = !reset && (md_start || (count != '0));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the five-stage pipeline
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic               clk,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  hz
);

    logic        md_start;
    logic        md_div;
    logic        md_busy;
    logic        haz_rs;
    logic        haz_rt;
    logic        md_stall;
    logic        epc_stall;
    logic        stall;
    logic [31:0] stall_cnt;

    // An exception in M kills the younger E instruction before it can start the MDU.
    assign md_div   = (hz.E_md_op == MD_DIV);
    assign md_start = ((hz.E_md_op == MD_MULT) || md_div) && !hz.Req && !reset;

    pipe_hazard_ctrl_md_busy_cnt #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_cnt (
        .clk      (clk),
        .reset    (reset),
        .md_start (md_start),
        .md_div   (md_div),
        .md_busy  (md_busy)
    );

    // Tuse of 3 never loses against a 2-bit Tnew, so unused operands need no special case.
    assign haz_rs = (hz.D_rs != 5'd0) &&
                    (((hz.E_wa == hz.D_rs) && (hz.E_Tnew > hz.D_Tuse_rs)) ||
                     ((hz.M_wa == hz.D_rs) && (hz.M_Tnew > hz.D_Tuse_rs)));
    assign haz_rt = (hz.D_rt != 5'd0) &&
                    (((hz.E_wa == hz.D_rt) && (hz.E_Tnew > hz.D_Tuse_rt)) ||
                     ((hz.M_wa == hz.D_rt) && (hz.M_Tnew > hz.D_Tuse_rt)));

    assign md_stall  = hz.D_is_md && md_busy;
    assign epc_stall = hz.D_eret && (hz.E_mtc0_epc || hz.M_mtc0_epc);
    assign stall     = !reset && !hz.Req && (haz_rs || haz_rt || md_stall || epc_stall);

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign hz.pc_en     = !stall;
    assign hz.fd_en     = !stall;
    assign hz.de_flush  = stall;
    assign hz.fd_flush  = hz.D_eret && !stall && !hz.Req && !reset;
    assign hz.md_start  = md_start;
    assign hz.md_busy   = md_busy;
    assign hz.stall     = stall;
    assign hz.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz ();

    pipe_hazard_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    // {pc_en, fd_en, fd_flush, de_flush, md_start, md_busy, stall}
    localparam logic [6:0] O_IDLE   = 7'b1100000;
    localparam logic [6:0] O_STALL  = 7'b0001001;
    localparam logic [6:0] O_MDST   = 7'b0001111;
    localparam logic [6:0] O_MDSTL  = 7'b0001011;
    localparam logic [6:0] O_MDGO   = 7'b1100110;
    localparam logic [6:0] O_MDRUN  = 7'b1100010;
    localparam logic [6:0] O_FDFL   = 7'b1110000;

    typedef struct {
        logic [6:0]  o;
        logic [31:0] sc;
        string       nm;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_sc = 32'd0;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t       x;
            logic [6:0] act;
            x   = sb.pop_front();
            act = {hz.pc_en, hz.fd_en, hz.fd_flush, hz.de_flush, hz.md_start, hz.md_busy, hz.stall};
            n_cmp++;
            if (act !== x.o) begin
                n_fail++;
                $display("FAIL %s ctrl: got %b expected %b", x.nm, act, x.o);
            end
            n_cmp++;
            if (hz.stall_cnt !== x.sc) begin
                n_fail++;
                $display("FAIL %s stall_cnt: got %0d expected %0d", x.nm, hz.stall_cnt, x.sc);
            end
        end
    end

    task automatic idle();
        hz.Req        = 1'b0;
        hz.D_rs       = 5'd0;
        hz.D_rt       = 5'd0;
        hz.D_Tuse_rs  = 2'd3;
        hz.D_Tuse_rt  = 2'd3;
        hz.E_wa       = 5'd0;
        hz.E_Tnew     = 2'd0;
        hz.M_wa       = 5'd0;
        hz.M_Tnew     = 2'd0;
        hz.D_is_md    = 1'b0;
        hz.E_md_op    = 2'd0;
        hz.D_eret     = 1'b0;
        hz.E_mtc0_epc = 1'b0;
        hz.M_mtc0_epc = 1'b0;
    endtask

    task automatic go(input logic [6:0] e, input string nm);
        exp_t x;
        x.o  = e;
        x.sc = exp_sc;
        x.nm = nm;
        sb.push_back(x);
        if (reset)     exp_sc = 32'd0;
        else if (e[0]) exp_sc = exp_sc + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic lw_hazard();
        hz.E_wa = 5'd8; hz.E_Tnew = 2'd2; hz.D_rs = 5'd8; hz.D_Tuse_rs = 2'd1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        lw_hazard(); hz.E_md_op = 2'd2; hz.D_is_md = 1'b1;
        go(O_IDLE, "reset_hold");
        reset = 1'b0;

        idle(); lw_hazard();
        go(O_STALL, "lw_rs_E");
        hz.D_rs = 5'd0;
        go(O_IDLE, "rs_zero");
        idle(); hz.M_wa = 5'd9; hz.M_Tnew = 2'd1; hz.D_rt = 5'd9; hz.D_Tuse_rt = 2'd0;
        go(O_STALL, "rt_M");
        hz.D_Tuse_rt = 2'd1;
        go(O_IDLE, "rt_M_equal");

        idle(); hz.E_md_op = 2'd2; hz.D_is_md = 1'b1;
        go(O_MDST, "div_start");
        hz.E_md_op = 2'd0;
        for (int i = 0; i < 10; i++) go(O_MDSTL, "div_busy");
        go(O_IDLE, "div_done");

        hz.E_md_op = 2'd1;
        go(O_MDST, "mult_start");
        hz.E_md_op = 2'd0;
        for (int i = 0; i < 5; i++) go(O_MDSTL, "mult_busy");
        go(O_IDLE, "mult_done");

        hz.E_md_op = 2'd3;
        go(O_IDLE, "md_rsvd");
        hz.E_md_op = 2'd1; hz.Req = 1'b1;
        go(O_IDLE, "mult_req_kill");
        hz.E_md_op = 2'd0; hz.Req = 1'b0;
        go(O_IDLE, "mult_req_nocount");

        idle(); hz.E_md_op = 2'd2;
        go(O_MDGO, "div_nostall_start");
        hz.E_md_op = 2'd0;
        for (int i = 0; i < 2; i++) go(O_MDRUN, "div_run");
        hz.Req = 1'b1; hz.D_is_md = 1'b1;
        for (int i = 0; i < 3; i++) go(O_MDRUN, "div_run_req");
        hz.Req = 1'b0;
        for (int i = 0; i < 5; i++) go(O_MDSTL, "div_run_after_req");
        go(O_IDLE, "div_run_done");

        idle(); hz.D_eret = 1'b1; hz.M_mtc0_epc = 1'b1;
        go(O_STALL, "eret_mtc0_M");
        hz.M_mtc0_epc = 1'b0;
        go(O_FDFL, "eret_flush");
        hz.E_mtc0_epc = 1'b1;
        go(O_STALL, "eret_mtc0_E");
        hz.E_mtc0_epc = 1'b0; hz.Req = 1'b1;
        go(O_IDLE, "eret_req");

        idle(); lw_hazard(); hz.Req = 1'b1;
        go(O_IDLE, "hazard_req");

        idle(); hz.E_md_op = 2'd2; hz.D_is_md = 1'b1;
        go(O_MDST, "div2_start");
        hz.E_md_op = 2'd0;
        for (int i = 0; i < 6; i++) go(O_MDSTL, "div2_busy");
        reset = 1'b1; hz.E_md_op = 2'd2; lw_hazard();
        go(O_IDLE, "reset_mid_div");
        reset = 1'b0; hz.E_md_op = 2'd0; hz.E_wa = 5'd0;
        go(O_IDLE, "after_reset");
        idle();
        go(O_IDLE, "final_idle");

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d entries left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
